// File: rtl/button_switch_controller_pkg.sv
// Shared constants for the button/switch input peripheral: register map,
// input counts and control-register bit positions.
package bsc_pkg;

  localparam int NUM_SW  = 16;
  localparam int NUM_BTN = 5;

  localparam logic [2:0] ADDR_SW_LO   = 3'd0;
  localparam logic [2:0] ADDR_SW_HI   = 3'd1;
  localparam logic [2:0] ADDR_BTN     = 3'd2;
  localparam logic [2:0] ADDR_BTN_EVT = 3'd3;
  localparam logic [2:0] ADDR_CTRL    = 3'd4;

  localparam int CTRL_IRQ_EN_BIT = 0;

endpackage

// File: rtl/button_switch_controller_debouncer.sv
// One input channel: 2-FF synchronizer, mismatch counter that must see
// DEBOUNCE_CYCLES consecutive disagreeing samples before the accepted level
// flips, and a one-cycle pulse when the accepted level goes 0->1.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt_q;
  logic          stable_q;
  logic          rise_q;

  // Synchronize, count consecutive mismatches, accept on the last one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q1 <= raw_i;
      sync_q2 <= sync_q1;
      rise_q  <= 1'b0;
      if (sync_q2 == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync_q2;
        cnt_q    <= '0;
        rise_q   <= sync_q2;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;

endmodule

// File: rtl/button_switch_controller.sv
// Memory-mapped input peripheral: debounced switch/button levels, sticky
// button-press events with write-1-to-clear, and a level interrupt.
module button_switch_controller
  import bsc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        we_i,
  input  logic [11:0] addr_i,
  input  logic [7:0]  din_i,
  output logic [7:0]  dout_o,
  input  logic [15:0] sw_i,
  input  logic [4:0]  btn_i,
  output logic        irq_o
);

  logic [NUM_SW-1:0]  sw_db;
  logic [NUM_SW-1:0]  sw_rise_unused;
  logic [NUM_BTN-1:0] btn_db;
  logic [NUM_BTN-1:0] btn_rise;

  logic [NUM_BTN-1:0] evt_q;
  logic [NUM_BTN-1:0] evt_clr;
  logic               irq_en_q;
  logic [7:0]         dout_q;
  logic [7:0]         rd_data;
  logic               wr_en;
  logic               rd_en;
  logic [2:0]         reg_addr;
  logic               addr_unused;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .raw_i    (sw_i[i]),
      .stable_o (sw_db[i]),
      .rise_o   (sw_rise_unused[i])
    );
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .raw_i    (btn_i[i]),
      .stable_o (btn_db[i]),
      .rise_o   (btn_rise[i])
    );
  end

  // Only the low three address bits decode; upper address and data bits
  // are don't-care.
  assign addr_unused = ^{addr_i[11:3], din_i[7:5]};

  assign reg_addr = addr_i[2:0];
  assign wr_en    = en_i & we_i;
  assign rd_en    = en_i & ~we_i;
  assign evt_clr  = (wr_en && reg_addr == ADDR_BTN_EVT) ? din_i[NUM_BTN-1:0] : '0;

  // Read mux over the byte registers; unmapped addresses read zero.
  always_comb begin
    rd_data = 8'h00;
    case (reg_addr)
      ADDR_SW_LO:   rd_data = sw_db[7:0];
      ADDR_SW_HI:   rd_data = sw_db[15:8];
      ADDR_BTN:     rd_data = {3'b000, btn_db};
      ADDR_BTN_EVT: rd_data = {3'b000, evt_q};
      ADDR_CTRL:    rd_data = {7'b0000000, irq_en_q};
      default:      rd_data = 8'h00;
    endcase
  end

  // Event latches (a new press beats a same-cycle clear), CTRL, read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evt_q    <= '0;
      irq_en_q <= 1'b0;
      dout_q   <= 8'h00;
    end else begin
      evt_q <= (evt_q & ~evt_clr) | btn_rise;
      if (wr_en && reg_addr == ADDR_CTRL) begin
        irq_en_q <= din_i[CTRL_IRQ_EN_BIT];
      end
      if (rd_en) begin
        dout_q <= rd_data;
      end
    end
  end

  assign dout_o = dout_q;
  assign irq_o  = irq_en_q & (|evt_q);

endmodule
